// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add the beat_count / stall_count statistics outputs.

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                     clk_w,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic [NUM_REQ-1:0]       grant,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_data_in,
  output logic                     busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    beat_count,
  output logic [15:0]              stall_count
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;
  localparam int CW = $clog2(BURST_MAX + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;

  logic [IW-1:0]       g_idx;
  logic [WIDTH-1:0]    g_data;
  logic                g_req;
  logic                beat;
  logic                last_beat;
  logic [IW-1:0]       nxt_ptr;
  logic [IW-1:0]       pick_idx;
  logic                pick_vld;
  logic [SW-1:0]       sum;

  always_comb begin
    g_idx  = '0;
    g_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx  = IW'(i);
        g_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign g_req     = |(req & grant_q);
  assign busy      = (state_q == S_BURST);
  assign beat      = busy && g_req && !fifo_full;
  assign last_beat = (beat_cnt_q == CW'(BURST_MAX - 1));
  assign nxt_ptr   = (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;

  // First active request at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SW'(k);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      if (!pick_vld && req[sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d    = S_BURST;
          grant_d    = NUM_REQ'(1) << pick_idx;
          beat_cnt_d = '0;
        end
      end
      S_BURST: begin
        if (!g_req || (beat && last_beat)) begin
          state_d    = S_IDLE;
          grant_d    = '0;
          rr_ptr_d   = nxt_ptr;
          beat_cnt_d = '0;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Write side is decoded from the registered grant, so reset silences it at once.
  assign grant        = grant_q;
  assign fifo_wr_en   = beat;
  assign req_ack      = beat ? grant_q : '0;
  assign fifo_data_in = beat ? g_data : '0;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] beat_count_q, beat_count_d;
  logic [15:0]           stall_count_q, stall_count_d;
  logic                  stall;

  assign stall = busy && g_req && fifo_full;

  always_comb begin
    beat_count_d  = beat_count_q;
    stall_count_d = stall_count_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (beat && grant_q[i] && (beat_count_q[i*16 +: 16] != 16'hFFFF)) begin
        beat_count_d[i*16 +: 16] = beat_count_q[i*16 +: 16] + 16'd1;
      end
    end
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus
// randomized traffic against a behavioural burst/round-robin model.

module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int BM = 4;

  logic          clk_w = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic [NR-1:0] grant;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [W-1:0]  fifo_data_in;
  logic          busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NR*16-1:0] beat_count;
  logic [15:0]      stall_count;
`endif

  fifo_wr_arbiter #(
    .NUM_REQ  (NR),
    .WIDTH    (W),
    .BURST_MAX(BM)
  ) dut (
    .clk_w       (clk_w),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .busy        (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .beat_count  (beat_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk_w = ~clk_w;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 when nobody owns the port), next candidate, beats so far.
  int m_own;
  int m_ptr;
  int m_cnt;

  logic          e_wr;
  logic          e_busy;
  logic [NR-1:0] e_ack;
  logic [NR-1:0] e_grant;
  logic [W-1:0]  e_data;

  logic [W-1:0]  fq[$];

  function automatic void model_reset();
    m_own = -1;
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_eval();
    e_busy  = (m_own >= 0);
    e_grant = '0;
    e_wr    = 1'b0;
    e_data  = '0;
    e_ack   = '0;
    if (e_busy) begin
      e_grant[m_own] = 1'b1;
      if (req[m_own] && !fifo_full) begin
        e_wr   = 1'b1;
        e_data = req_data[m_own*W +: W];
        e_ack  = e_grant;
      end
    end
  endfunction

  function automatic void model_next();
    if (m_own < 0) begin
      for (int k = 0; k < NR; k++) begin
        if (m_own < 0 && req[(m_ptr + k) % NR]) begin
          m_own = (m_ptr + k) % NR;
          m_cnt = 0;
        end
      end
    end else if (!req[m_own]) begin
      m_ptr = (m_own + 1) % NR;
      m_own = -1;
    end else if (!fifo_full) begin
      m_cnt++;
      if (m_cnt == BM) begin
        m_ptr = (m_own + 1) % NR;
        m_own = -1;
      end
    end
  endfunction

  task automatic settle();
    @(negedge clk_w);
    model_eval();
  endtask

  // The bench acts as an 8-deep FIFO: it stores what the DUT writes.
  task automatic advance(input bit pop);
    if (fifo_wr_en && !fifo_full) fq.push_back(fifo_data_in);
    if (pop && fq.size() > 0) void'(fq.pop_front());
    model_next();
    @(posedge clk_w);
    #1;
    fifo_full = (fq.size() >= 8);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    fq.delete();
    model_reset();
    @(posedge clk_w);
    @(posedge clk_w);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b1;
    req       = 4'hF;
    req_data  = {4{32'h5555AAAA}};
    fifo_full = 1'b0;
    fq.delete();
    model_reset();
    #2 rst_n = 1'b0;
    @(negedge clk_w);
    if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !== 42'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {grant, busy, fifo_wr_en, req_ack, fifo_data_in});
    end
    checks++;
    @(posedge clk_w);
    #1 rst_n = 1'b1;
    settle();
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle grant=%b busy=%b exp 0000/0", grant, busy);
    end
    checks++;
    advance(0);
    settle();
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got=%b exp=0001", grant);
    end
    checks++;
  endtask

  task automatic test_single();
    int sent = 0;
    logic [9:0] pat = '0;
    logic ackd;
    do_reset();
    req[0] = 1'b1;
    req_data[31:0] = 32'h1234ABCD;
    for (int c = 0; c < 10; c++) begin
      settle();
      if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !==
          {e_grant, e_busy, e_wr, e_ack, e_data}) begin
        errors++;
        $display("FAIL single_c%0d got=%h exp=%h", c,
                 {grant, busy, fifo_wr_en, req_ack, fifo_data_in},
                 {e_grant, e_busy, e_wr, e_ack, e_data});
      end
      checks++;
      if (c == 1) begin
        if (grant !== 4'b0001) begin
          errors++;
          $display("FAIL single_grant got=%b exp=0001", grant);
        end
        checks++;
      end
      pat  = {pat[8:0], fifo_wr_en};
      ackd = req_ack[0];
      advance(0);
      if (ackd) begin
        sent++;
        if (sent == 6) req[0] = 1'b0;
        else req_data[31:0] = 32'h1234ABCD + sent;
      end
    end
    if (pat !== 10'b0111101100) begin
      errors++;
      $display("FAIL single_pattern got=%b exp=0111101100", pat);
    end
    checks++;
    if (fq.size() != 6) begin
      errors++;
      $display("FAIL single_count got=%0d exp=6", fq.size());
    end
    checks++;
    for (int k = 0; k < 6; k++) begin
      if (k < fq.size()) begin
        if (fq[k] !== 32'h1234ABCD + k) begin
          errors++;
          $display("FAIL single_word%0d got=%h exp=%h", k, fq[k],
                   32'h1234ABCD + k);
        end
        checks++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gexp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [3:0] gseq[5];
    int wcnt[5] = '{0, 0, 0, 0, 0};
    int nb = 0;
    logic pb = 1'b0;
    do_reset();
    req = 4'hF;
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 32'hA000_0000 + i;
    for (int c = 0; c < 26; c++) begin
      settle();
      if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !==
          {e_grant, e_busy, e_wr, e_ack, e_data}) begin
        errors++;
        $display("FAIL rr_c%0d got=%h exp=%h", c,
                 {grant, busy, fifo_wr_en, req_ack, fifo_data_in},
                 {e_grant, e_busy, e_wr, e_ack, e_data});
      end
      checks++;
      if (busy && !pb && nb < 5) begin
        gseq[nb] = grant;
        nb++;
`ifdef FIFO_WR_ARB_STATS_EN
        if (nb == 5) begin
          if (beat_count !== {4{16'd4}}) begin
            errors++;
            $display("FAIL rr_beat_count got=%h exp=%h", beat_count,
                     {4{16'd4}});
          end
          checks++;
        end
`endif
      end
      if (fifo_wr_en && nb > 0) wcnt[nb-1]++;
      pb = busy;
      advance(1);
    end
    if (nb != 5) begin
      errors++;
      $display("FAIL rr_bursts got=%0d exp=5", nb);
    end
    checks++;
    for (int b = 0; b < nb; b++) begin
      if (gseq[b] !== gexp[b]) begin
        errors++;
        $display("FAIL rr_grant%0d got=%b exp=%b", b, gseq[b], gexp[b]);
      end
      checks++;
      if (wcnt[b] != BM) begin
        errors++;
        $display("FAIL rr_writes%0d got=%0d exp=%0d", b, wcnt[b], BM);
      end
      checks++;
    end
  endtask

  task automatic test_full_throttle();
    int writes = 0;
    logic ackd;
    do_reset();
    for (int k = 0; k < 8; k++) fq.push_back(32'hDEAD_0000 + k);
    fifo_full = 1'b1;
    req = 4'b0100;
    req_data[95:64] = 32'hCAFEBABE;
    for (int c = 0; c < 9; c++) begin
      settle();
      if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !==
          {e_grant, e_busy, e_wr, e_ack, e_data}) begin
        errors++;
        $display("FAIL full_c%0d got=%h exp=%h", c,
                 {grant, busy, fifo_wr_en, req_ack, fifo_data_in},
                 {e_grant, e_busy, e_wr, e_ack, e_data});
      end
      checks++;
      if (c >= 1 && c <= 5) begin
        if (grant !== 4'b0100 || fifo_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL full_hold_c%0d grant=%b wr=%b exp 0100/0", c,
                   grant, fifo_wr_en);
        end
        checks++;
      end
      if (c == 6) begin
        if ({fifo_wr_en, req_ack, fifo_data_in} !== {1'b1, 4'b0100, 32'hCAFEBABE}) begin
          errors++;
          $display("FAIL full_write got=%h exp=%h",
                   {fifo_wr_en, req_ack, fifo_data_in},
                   {1'b1, 4'b0100, 32'hCAFEBABE});
        end
        checks++;
      end
      if (fifo_wr_en) writes++;
      ackd = req_ack[2];
      advance(c == 5);
      if (ackd) req[2] = 1'b0;
    end
    if (writes != 1) begin
      errors++;
      $display("FAIL full_writes got=%0d exp=1", writes);
    end
    checks++;
`ifdef FIFO_WR_ARB_STATS_EN
    if (stall_count !== 16'd5) begin
      errors++;
      $display("FAIL full_stall_count got=%0d exp=5", stall_count);
    end
    checks++;
`endif
  endtask

  task automatic test_early_release();
    int acks = 0;
    logic ackd;
    do_reset();
    req = 4'b0010;
    req_data[63:32] = 32'hB000_0001;
    req_data[31:0]  = 32'hE000_0000;
    for (int c = 0; c < 6; c++) begin
      settle();
      if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !==
          {e_grant, e_busy, e_wr, e_ack, e_data}) begin
        errors++;
        $display("FAIL early_c%0d got=%h exp=%h", c,
                 {grant, busy, fifo_wr_en, req_ack, fifo_data_in},
                 {e_grant, e_busy, e_wr, e_ack, e_data});
      end
      checks++;
      if (c == 3) begin
        if (busy !== 1'b1 || fifo_wr_en !== 1'b0) begin
          errors++;
          $display("FAIL early_exit busy=%b wr=%b exp 1/0", busy, fifo_wr_en);
        end
        checks++;
      end
      if (c == 4) begin
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL early_idle busy=%b exp=0", busy);
        end
        checks++;
      end
      if (c == 5) begin
        if (grant !== 4'b0001) begin
          errors++;
          $display("FAIL early_next_grant got=%b exp=0001", grant);
        end
        checks++;
      end
      ackd = req_ack[1];
      advance(1);
      if (ackd) begin
        acks++;
        if (acks == 2) req = 4'b0001;
      end
      if (c == 3) req = 4'b0011;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0100;
    req_data[95:64] = 32'h7777_0002;
    for (int c = 0; c < 2; c++) begin
      settle();
      if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !==
          {e_grant, e_busy, e_wr, e_ack, e_data}) begin
        errors++;
        $display("FAIL rstmid_c%0d got=%h exp=%h", c,
                 {grant, busy, fifo_wr_en, req_ack, fifo_data_in},
                 {e_grant, e_busy, e_wr, e_ack, e_data});
      end
      checks++;
      advance(1);
    end
    settle();
    if (fifo_wr_en !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_beat2 wr=%b exp=1", fifo_wr_en);
    end
    checks++;
    #1 rst_n = 1'b0;
    #1;
    if ({grant, busy, fifo_wr_en, req_ack} !== 10'h0) begin
      errors++;
      $display("FAIL rstmid_async grant=%b busy=%b wr=%b ack=%b exp 0",
               grant, busy, fifo_wr_en, req_ack);
    end
    checks++;
    model_reset();
    fq.delete();
    fifo_full = 1'b0;
    @(posedge clk_w);
    #1 rst_n = 1'b1;
    req = 4'hF;
    settle();
    if ({grant, busy, fifo_wr_en} !== {e_grant, e_busy, e_wr}) begin
      errors++;
      $display("FAIL rstmid_idle got=%h exp=%h", {grant, busy, fifo_wr_en},
               {e_grant, e_busy, e_wr});
    end
    checks++;
    advance(1);
    settle();
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_restart got=%b exp=0001", grant);
    end
    checks++;
  endtask

  task automatic test_random();
    logic [NR-1:0] ackd;
    bit pop;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      settle();
      if ({grant, busy, fifo_wr_en, req_ack, fifo_data_in} !==
          {e_grant, e_busy, e_wr, e_ack, e_data}) begin
        errors++;
        $display("FAIL rand_c%0d got=%h exp=%h", c,
                 {grant, busy, fifo_wr_en, req_ack, fifo_data_in},
                 {e_grant, e_busy, e_wr, e_ack, e_data});
      end
      checks++;
      if (fifo_wr_en && fifo_full) begin
        errors++;
        $display("FAIL rand_wr_full_c%0d wr=1 full=1 exp wr=0", c);
      end
      checks++;
      ackd = e_ack;
      pop  = ($urandom_range(0, 9) < (((c / 100) % 2 == 1) ? 8 : 3));
      advance(pop);
      for (int i = 0; i < NR; i++) begin
        if (ackd[i]) begin
          if ($urandom_range(0, 3) != 0) req_data[i*W +: W] = $urandom;
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = $urandom;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_throttle();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
